mem_access_unit: RTL
====================

# mem_access_unit

Parametrised load/store unit for the Memory stage of the pipelined MIPS core. It replaces the single-cycle memory path with a registered request/acknowledge port to the data bus, so it works with variable-latency memory. It handles byte, half, word and (when the data width is 64) dword accesses, with sign or zero extension. It detects misaligned accesses and bus timeouts and reports them as exceptions, and it stalls the pipeline while a transaction is outstanding.

## Interface
Parameters:
- DW, 32, data width in bits; legal values 32 or 64.
- AW, 32, address width.
- TIMEOUT, 16, cycles bus_req may stay high without bus_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock; every register updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  the Memory stage presents a load/store this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_width  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_signed  in  1  sign-extend the load result (ignored for stores).
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, right-aligned (the raw rt value).
- req_ready  out  1  the unit is idle and accepts a request.
- stall  out  1  freeze the pipeline.
- resp_valid  out  1  one-cycle pulse: load data is valid, or the store has completed.
- resp_rdata  out  DW  extended load data; 0 for stores.
- exc_valid  out  1  one-cycle exception pulse.
- exc_code  out  2  1 = misaligned load, 2 = misaligned/illegal store, 3 = bus timeout.
- bus_req  out  1  bus request; held high until acknowledged.
- bus_we  out  1  bus write.
- bus_addr  out  AW  req_addr with the low log2(DW/8) bits cleared.
- bus_byteen  out  DW/8  byte lane enables.
- bus_wdata  out  DW  store data shifted into its byte lanes.
- bus_ack  in  1  bus transaction complete; bus_rdata is valid in the same cycle.
- bus_rdata  in  DW  full-width read data.

## Operation
- States: IDLE, WAIT.
- req_ready = (state == IDLE).
- stall = req_valid && accepted this cycle, or state == WAIT. Computed combinationally.
- Access size: size = 1 << req_width bytes. The lane offset is off = req_addr mod (DW/8).
- A request is illegal when off mod size != 0, or when req_width == 3 with DW == 32.
- IDLE, req_valid with an illegal request:
  - no bus activity;
  - next cycle exc_valid = 1 with exc_code = req_we ? 2 : 1;
  - the unit stays in IDLE.
- IDLE, req_valid with a legal request:
  - register bus_addr, bus_we, bus_byteen, bus_wdata, off, size and signed;
  - bus_byteen = ((1 << size) - 1) << off;
  - bus_wdata = req_wdata << (8*off);
  - set bus_req = 1; go to WAIT; clear the timeout counter.
- WAIT:
  - All bus outputs are held stable.
  - On bus_ack:
    - load: data = bus_rdata >> (8*off), truncated to size*8 bits, then sign- or zero-extended to DW;
    - store: data = 0;
    - register resp_rdata = data and resp_valid = 1; drop bus_req; return to IDLE.
  - Otherwise, when TIMEOUT != 0 and the counter reaches TIMEOUT-1: drop bus_req, pulse exc_valid with code 3, return to IDLE.
  - Otherwise increment the counter.
- Boundary conditions:
  - bus_ack in the same cycle as the timeout expiry: ack wins, no exception.
  - bus_ack while IDLE: ignored.
  - req_valid while in WAIT: ignored. The pipeline is stalled and re-presents the request.
- Reset low, at any time including mid-WAIT:
  - state goes to IDLE and the counter to 0;
  - bus_req, bus_we, bus_byteen, bus_wdata, bus_addr, resp_valid, resp_rdata, exc_valid and exc_code all go to 0 immediately;
  - an ack arriving after release for the aborted transaction is ignored.

## Timing
- A request is accepted in cycle T, bus_req is high from T+1, and bus_ack is sampled in T+k (k ≥ 1).
- resp_valid is high in T+k+1 only. Minimum load/store latency is 2 cycles.
- The next request can be accepted in T+k+1, the same cycle as resp_valid, giving back-to-back throughput of one access per k+1 cycles.
- Misaligned request in T: exc_valid in T+1 only, and req_ready stays 1.
- Timeout: bus_req is high for exactly TIMEOUT cycles (T+1 through T+TIMEOUT), exc_valid is high in T+TIMEOUT+1, and bus_req is 0 in that cycle.
- resp_valid and exc_valid are never high in the same cycle.

## Test plan
- Signed half-word load, DW = 32:
  - stimulus: lh at addr 0x0000_1002, ack 3 cycles after bus_req rises, bus_rdata = 0x8001_7FFF;
  - expect: bus_addr = 0x0000_1000, bus_byteen = 4'b1100, resp_rdata = 0xFFFF_8001, resp_valid exactly one cycle at T+4, stall high from T through T+3.
- Unsigned byte load:
  - stimulus: lbu at 0x03, bus_rdata = 0x9A00_0000, ack in the first WAIT cycle;
  - expect: resp_rdata = 0x0000_009A at T+2.
- Byte store:
  - stimulus: sb at 0x0000_2003 with req_wdata = 0x1234_56A5;
  - expect: bus_byteen = 4'b1000, bus_wdata = 0xA500_0000, bus_we = 1, resp_rdata = 0.
- Misaligned accesses:
  - stimulus: lw at 0x...02; then sh at 0x...01; then width 3 with DW = 32;
  - expect: exc codes 1, 2 and 2 respectively, each one cycle later; bus_req never rises.
- Timeout, TIMEOUT = 8:
  - stimulus: no ack — expect bus_req high 8 cycles, then exc_code 3 pulse, req_ready = 1.
  - stimulus: ack on the 8th cycle — expect a normal response and no exception.
- Reset during WAIT:
  - stimulus: reset low in the 2nd WAIT cycle;
  - expect: all outputs 0 immediately; a stale ack after release produces no resp_valid; a new lw at 0x...04 completes normally.
- DW = 64:
  - stimulus: ld at 0x...08, then signed lw at 0x...0C with bus_rdata[63:32] = 0xF000_0000;
  - expect: bus_byteen 0xFF, then 0xF0; resp_rdata = 0xFFFF_FFFF_F000_0000.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit for the Memory stage. A request is checked for alignment and
// then issued as a single registered bus transaction held until bus_ack_i. The
// pipeline is stalled while a transaction is outstanding. Load data is lane-shifted
// and sign/zero-extended. Misaligned requests and bus timeouts raise one-cycle
// exceptions.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i, req_we_i          request strobe, 1 = store
//   req_width_i                    0 byte, 1 half, 2 word, 3 dword
//   req_signed_i                   sign-extend load result
//   req_addr_i, req_wdata_i        byte address, right-aligned store data
//   req_ready_o, stall_o           idle / freeze pipeline
//   resp_valid_o, resp_rdata_o     completion pulse and extended load data
//   exc_valid_o, exc_code_o        exception pulse; 1 ld misalign, 2 st misalign, 3 timeout
//   bus_req_o .. bus_wdata_o       registered bus request
//   bus_ack_i, bus_rdata_i         bus completion and full-width read data
module mem_access_unit #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  input  logic            req_we_i,
  input  logic [1:0]      req_width_i,
  input  logic            req_signed_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  output logic            req_ready_o,
  output logic            stall_o,
  output logic            resp_valid_o,
  output logic [DW-1:0]   resp_rdata_o,
  output logic            exc_valid_o,
  output logic [1:0]      exc_code_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [AW-1:0]   bus_addr_o,
  output logic [DW/8-1:0] bus_byteen_o,
  output logic [DW-1:0]   bus_wdata_o,
  input  logic            bus_ack_i,
  input  logic [DW-1:0]   bus_rdata_i
);

  localparam int unsigned NB   = DW / 8;
  localparam int unsigned OffW = $clog2(NB);
  localparam int unsigned IdxW = $clog2(DW);
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TimeoutEn = (TIMEOUT != 0);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q;
  logic            bus_req_q, bus_we_q;
  logic [AW-1:0]   bus_addr_q;
  logic [NB-1:0]   bus_byteen_q;
  logic [DW-1:0]   bus_wdata_q;
  logic [OffW-1:0] off_q;
  logic [1:0]      width_q;
  logic            signed_q;
  logic [CntW-1:0] cnt_q;
  logic            resp_valid_q, exc_valid_q;
  logic [DW-1:0]   resp_rdata_q;
  logic [1:0]      exc_code_q;

  // Request decode
  logic [OffW-1:0] req_off, align_mask;
  logic [4:0]      size_bytes;
  logic            req_illegal;
  logic [NB-1:0]   byteen_d;
  logic [DW-1:0]   wdata_d;

  always_comb begin
    req_off     = req_addr_i[OffW-1:0];
    size_bytes  = 5'd1 << req_width_i;
    // Width 3 truncates to an all-ones mask here; on DW=32 it is rejected below anyway.
    align_mask  = OffW'(size_bytes - 5'd1);
    req_illegal = (|(req_off & align_mask)) || ((req_width_i == 2'd3) && (DW == 32));
    for (int i = 0; i < NB; i++) begin
      byteen_d[i] = (5'(i) >= 5'(req_off)) && (5'(i) < 5'(req_off) + size_bytes);
    end
    wdata_d = req_wdata_i << {req_off, 3'b000};
  end

  // Load extraction: bits above the access's top bit copy it (signed) or are zero.
  logic [DW-1:0]   rd_shifted, load_data;
  logic [IdxW-1:0] top_bit;

  always_comb begin
    rd_shifted = bus_rdata_i >> {off_q, 3'b000};
    top_bit    = IdxW'((7'd8 << width_q) - 7'd1);
    for (int i = 0; i < DW; i++) begin
      load_data[i] = (IdxW'(i) <= top_bit) ? rd_shifted[i] : (signed_q & rd_shifted[top_bit]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_byteen_q <= '0;
      bus_wdata_q  <= '0;
      off_q        <= '0;
      width_q      <= '0;
      signed_q     <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      exc_valid_q  <= 1'b0;
      exc_code_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      exc_valid_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            if (req_illegal) begin
              exc_valid_q <= 1'b1;
              exc_code_q  <= req_we_i ? 2'd2 : 2'd1;
            end else begin
              bus_req_q    <= 1'b1;
              bus_we_q     <= req_we_i;
              bus_addr_q   <= {req_addr_i[AW-1:OffW], {OffW{1'b0}}};
              bus_byteen_q <= byteen_d;
              bus_wdata_q  <= wdata_d;
              off_q        <= req_off;
              width_q      <= req_width_i;
              signed_q     <= req_signed_i;
              cnt_q        <= '0;
              state_q      <= StWait;
            end
          end
        end
        StWait: begin
          // Ack has priority over a timeout expiring in the same cycle.
          if (bus_ack_i) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= bus_we_q ? '0 : load_data;
            bus_req_q    <= 1'b0;
            state_q      <= StIdle;
          end else if (TimeoutEn && (cnt_q == CntLast)) begin
            bus_req_q   <= 1'b0;
            exc_valid_q <= 1'b1;
            exc_code_q  <= 2'd3;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  // Requests are only ever presented while idle or already stalled, so any
  // req_valid_i is either being accepted or waiting on the current transaction.
  assign stall_o      = req_valid_i || (state_q == StWait);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign exc_valid_o  = exc_valid_q;
  assign exc_code_o   = exc_code_q;
  assign bus_req_o    = bus_req_q;
  assign bus_we_o     = bus_we_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_byteen_o = bus_byteen_q;
  assign bus_wdata_o  = bus_wdata_q;

endmodule
